// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage hazard, forwarding and multi-cycle hold controller
module hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_destreg,
    input  logic             id_regwrite,
    input  logic             id_load,
    input  logic             id_multi,
    input  logic             id_taken,
    output logic             stall,
    output logic             squash,
    output logic [1:0]       aluselectA,
    output logic [1:0]       aluselectB,
    output logic             ex_hold,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MC_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam logic [MC_W-1:0] MC_INIT = MC_W'(MC_LAT - 1);

    // Destination tracking for the instructions currently in EX and MEM
    logic [4:0]      ex_dst;
    logic            ex_wr;
    logic            ex_load;
    logic [4:0]      mem_dst;
    logic            mem_wr;
    logic [MC_W-1:0] mc_cnt;

    logic ex_match_a, ex_match_b, mem_match_a, mem_match_b;
    logic load_use, hold_raw, stall_raw;

    // Match detection; a source that is not read never matches
    always_comb begin
        ex_match_a  = id_use_rs1 && ex_wr  && (ex_dst  == id_rs1) && (id_rs1 != 5'd0);
        ex_match_b  = id_use_rs2 && ex_wr  && (ex_dst  == id_rs2) && (id_rs2 != 5'd0);
        mem_match_a = id_use_rs1 && mem_wr && (mem_dst == id_rs1) && (id_rs1 != 5'd0);
        mem_match_b = id_use_rs2 && mem_wr && (mem_dst == id_rs2) && (id_rs2 != 5'd0);
        load_use    = (ex_match_a || ex_match_b) && ex_load;
        hold_raw    = (mc_cnt != '0);
        stall_raw   = hold_raw || load_use;
    end

    // Output decode; everything is forced quiet while reset is asserted
    always_comb begin
        aluselectA = 2'b00;
        aluselectB = 2'b00;
        if (ex_match_a && !ex_load) begin
            aluselectA = 2'b01;
        end else if (mem_match_a) begin
            aluselectA = 2'b10;
        end
        if (ex_match_b && !ex_load) begin
            aluselectB = 2'b01;
        end else if (mem_match_b) begin
            aluselectB = 2'b10;
        end
        if (!reset_n) begin
            aluselectA = 2'b00;
            aluselectB = 2'b00;
        end
        ex_hold = reset_n && hold_raw;
        stall   = reset_n && stall_raw;
        squash  = reset_n && id_taken && !stall_raw;
    end

    // Pipeline tracking: hold keeps EX and drains MEM, stall bubbles EX, else advance
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_dst  <= 5'd0;
            ex_wr   <= 1'b0;
            ex_load <= 1'b0;
            mem_dst <= 5'd0;
            mem_wr  <= 1'b0;
        end else if (hold_raw) begin
            mem_dst <= 5'd0;
            mem_wr  <= 1'b0;
        end else if (stall_raw) begin
            mem_dst <= ex_dst;
            mem_wr  <= ex_wr;
            ex_dst  <= 5'd0;
            ex_wr   <= 1'b0;
            ex_load <= 1'b0;
        end else begin
            mem_dst <= ex_dst;
            mem_wr  <= ex_wr;
            ex_dst  <= id_destreg;
            ex_wr   <= id_regwrite;
            ex_load <= id_load;
        end
    end

    // Multi-cycle occupancy counter, loaded when a multi-cycle op enters EX
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mc_cnt <= '0;
        end else if (hold_raw) begin
            mc_cnt <= mc_cnt - MC_W'(1);
        end else if (!stall_raw && id_multi) begin
            mc_cnt <= MC_INIT;
        end
    end

    // Free-running count of stalled cycles, wraps naturally
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stall_raw) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
